fifo_sync: RTL and testbench

FIFO_SYNC -- requirements
Module: fifo_sync

---
 rtl/fifo_sync_pkg.sv | 18 +
 rtl/fifo_if.sv | 14 +
 rtl/fifo_sync_mem.sv | 24 ++
 rtl/fifo_sync.sv | 69 ++++++
 tb/tb_fifo_sync.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/fifo_sync_pkg.sv
// Shared definitions for the synchronous FIFO: encoding of the per-cycle
// pointer/count operation derived from the two handshakes.
package fifo_sync_pkg;

  // Bit 0 = write accepted, bit 1 = read accepted.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_BOTH  = 2'b11
  } fifo_op_e;

  // Collapse the two accepted handshakes into one operation code.
  function automatic fifo_op_e fifo_op(input logic wr, input logic rd);
    return fifo_op_e'({rd, wr});
  endfunction

endpackage

// File: rtl/fifo_if.sv
// Valid/ready stream bundle shared by producers and consumers of the FIFO.
// Modport "in" is the sink view (FIFO write side), "out" the source view.
interface FIFOInterface #(
  parameter int num_bits = 16
) (
  input logic clock
);
  logic [num_bits-1:0] data;
  logic                valid;
  logic                ready;

  modport in  (input  data, input  valid, output ready, input clock);
  modport out (output data, output valid, input  ready, input clock);
endinterface

// File: rtl/fifo_sync_mem.sv
// D x Nb register array: one synchronous write port, one combinational
// read port so the head word falls through without a cycle of latency.
module fifo_sync_mem #(
  parameter int Nb = 16,
  parameter int M  = 9
) (
  input  logic          ifclk_delayed,
  input  logic          we_i,
  input  logic [M-1:0]  waddr_i,
  input  logic [Nb-1:0] wdata_i,
  input  logic [M-1:0]  raddr_i,
  output logic [Nb-1:0] rdata_o
);
  localparam int D = 1 << M;

  logic [Nb-1:0] mem_q [D];

  // Store the accepted word at the tail; contents are never reset.
  always_ff @(posedge ifclk_delayed) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/fifo_sync.sv
// Single-clock first-word-fall-through FIFO with valid/ready handshakes on
// both sides. Flags come from the registered count only, so in.ready never
// depends on out.ready (a full FIFO refuses a write even while being read).
module fifo_sync
  import fifo_sync_pkg::*;
#(
  parameter int Nb = 16,
  parameter int M  = 9
) (
  input  logic       ifclk_delayed,
  input  logic       reset,
  FIFOInterface.in   in,
  FIFOInterface.out  out,
  output logic [M:0] count
);
  localparam logic [M:0] DEPTH = {1'b1, {M{1'b0}}};

  logic [M-1:0] wr_ptr_q, wr_ptr_d;
  logic [M-1:0] rd_ptr_q, rd_ptr_d;
  logic [M:0]   count_q,  count_d;
  logic         wr_en, rd_en;
  fifo_op_e     op;

  assign in.ready  = (count_q != DEPTH);
  assign out.valid = (count_q != '0);
  assign wr_en     = in.valid  && in.ready;
  assign rd_en     = out.valid && out.ready;
  assign op        = fifo_op(wr_en, rd_en);
  assign count     = count_q;

  fifo_sync_mem #(
    .Nb (Nb),
    .M  (M)
  ) u_mem (
    .ifclk_delayed (ifclk_delayed),
    .we_i          (wr_en),
    .waddr_i       (wr_ptr_q),
    .wdata_i       (in.data),
    .raddr_i       (rd_ptr_q),
    .rdata_o       (out.data)
  );

  // Next pointers and occupancy; M-bit pointers wrap modulo D on their own.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    case (op)
      OP_WRITE: count_d = count_q + 1'b1;
      OP_READ:  count_d = count_q - 1'b1;
      default:  count_d = count_q;
    endcase
  end

  // State register; reset wins over any same-cycle handshake and empties the queue.
  always_ff @(posedge ifclk_delayed) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: tb/tb_fifo_sync.sv
// Scoreboard bench for fifo_sync (Nb=16, M=9): accepted writes are queued,
// every accepted read pops the queue and is compared with out.data.
module tb_fifo_sync;
  localparam int NB = 16;
  localparam int M  = 9;
  localparam int D  = 1 << M;

  logic          clk = 1'b0;
  logic          rst;
  logic [M:0]    count;
  logic [NB-1:0] sb[$];
  int            model_cnt = 0;
  int            n_vec = 0;
  int            n_bad = 0;
  bit            verbose = 1'b0;

  always #5 clk = ~clk;

  FIFOInterface #(.num_bits(NB)) wr_if (.clock(clk));
  FIFOInterface #(.num_bits(NB)) rd_if (.clock(clk));

  fifo_sync #(.Nb(NB), .M(M)) dut (
    .ifclk_delayed (clk),
    .reset         (rst),
    .in            (wr_if),
    .out           (rd_if),
    .count         (count)
  );

  // One clock of stimulus starting at a falling edge. Returns the word seen on
  // out.data and the scoreboard word when the model expects a read to happen.
  task automatic step(input logic wv, input logic [NB-1:0] wd, input logic rr,
                      output bit popped, output logic [NB-1:0] got,
                      output logic [NB-1:0] want);
    int  pre;
    bit  pushed;
    wr_if.valid = wv;
    wr_if.data  = wd;
    rd_if.ready = rr;
    #1;
    pre    = model_cnt;
    popped = rr && (pre != 0);
    pushed = wv && (pre < D);
    got    = rd_if.data;
    want   = '0;
    if (popped) want = sb.pop_front();
    if (pushed) sb.push_back(wd);
    model_cnt = pre - int'(popped) + int'(pushed);
    if (verbose)
      $display("  txn wr=%0b data=%h rd=%0b out=%h -> count %0d", pushed, wd, popped, got, model_cnt);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic wv, input logic rr);
    rst         = 1'b1;
    wr_if.valid = wv;
    wr_if.data  = 16'h5555;
    rd_if.ready = rr;
    @(negedge clk);
    rst         = 1'b0;
    wr_if.valid = 1'b0;
    rd_if.ready = 1'b0;
    sb.delete();
    model_cnt = 0;
  endtask

  task automatic test_reset();
    bit p; logic [NB-1:0] g, w;
    do_reset(1'b1, 1'b1);
    step(1'b0, '0, 1'b0, p, g, w);
    step(1'b0, '0, 1'b1, p, g, w);
    n_vec++; if (count !== 10'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
    n_vec++; if (wr_if.ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", wr_if.ready); end
    n_vec++; if (rd_if.valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", rd_if.valid); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    bit p; logic [NB-1:0] g, w;
    verbose = 1'b1;
    step(1'b1, 16'h1234, 1'b0, p, g, w);
    n_vec++; if (count !== 10'd1) begin n_bad++; $display("FAIL single_count: got %0d want 1", count); end
    n_vec++; if (rd_if.valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", rd_if.valid); end
    n_vec++; if (rd_if.data !== 16'h1234) begin n_bad++; $display("FAIL single_data: got %h want 1234", rd_if.data); end
    step(1'b0, '0, 1'b1, p, g, w);
    n_vec++; if (!p || g !== w) begin n_bad++; $display("FAIL single_pop: got %h want %h popped %0b", g, w, p); end
    n_vec++; if (count !== 10'd0) begin n_bad++; $display("FAIL single_count_after: got %0d want 0", count); end
    n_vec++; if (rd_if.valid !== 1'b0) begin n_bad++; $display("FAIL single_valid_after: got %b want 0", rd_if.valid); end
    // A read request on an empty FIFO must change nothing.
    step(1'b0, '0, 1'b1, p, g, w);
    n_vec++; if (count !== 10'd0) begin n_bad++; $display("FAIL empty_read_count: got %0d want 0", count); end
    verbose = 1'b0;
    $display("test_single done");
  endtask

  task automatic test_fill_drain();
    bit p; logic [NB-1:0] g, w;
    for (int i = 0; i < D; i++) step(1'b1, NB'(i), 1'b0, p, g, w);
    n_vec++; if (count !== 10'd512) begin n_bad++; $display("FAIL full_count: got %0d want 512", count); end
    n_vec++; if (wr_if.ready !== 1'b0) begin n_bad++; $display("FAIL full_in_ready: got %b want 0", wr_if.ready); end
    step(1'b1, 16'hDEAD, 1'b0, p, g, w);
    n_vec++; if (count !== 10'd512) begin n_bad++; $display("FAIL overflow_count: got %0d want 512", count); end
    for (int i = 0; i < D; i++) begin
      step(1'b0, '0, 1'b1, p, g, w);
      n_vec++;
      if (!p || g !== w || g !== NB'(i)) begin
        n_bad++; $display("FAIL drain[%0d]: got %h want %h", i, g, w);
      end
    end
    n_vec++; if (count !== 10'd0) begin n_bad++; $display("FAIL drained_count: got %0d want 0", count); end
    n_vec++; if (rd_if.valid !== 1'b0) begin n_bad++; $display("FAIL drained_valid: got %b want 0", rd_if.valid); end
    $display("test_fill_drain done");
  endtask

  task automatic test_full_rw();
    bit p; logic [NB-1:0] g, w;
    for (int i = 0; i < D; i++) step(1'b1, NB'(16'h4000 + i), 1'b0, p, g, w);
    step(1'b1, 16'hBEEF, 1'b1, p, g, w);
    n_vec++; if (!p || g !== w) begin n_bad++; $display("FAIL full_rw_pop: got %h want %h", g, w); end
    n_vec++; if (count !== 10'd511) begin n_bad++; $display("FAIL full_rw_count: got %0d want 511", count); end
    n_vec++; if (wr_if.ready !== 1'b1) begin n_bad++; $display("FAIL full_rw_in_ready: got %b want 1", wr_if.ready); end
    for (int i = 1; i < D; i++) begin
      step(1'b0, '0, 1'b1, p, g, w);
      n_vec++;
      if (!p || g !== w || g !== NB'(16'h4000 + i)) begin
        n_bad++; $display("FAIL full_rw_drain[%0d]: got %h want %h", i, g, w);
      end
    end
    n_vec++; if (count !== 10'd0) begin n_bad++; $display("FAIL full_rw_end_count: got %0d want 0", count); end
    $display("test_full_rw done");
  endtask

  task automatic test_back_to_back();
    bit p; logic [NB-1:0] g, w;
    for (int i = 0; i < 5; i++) step(1'b1, NB'(16'h0100 + i), 1'b0, p, g, w);
    for (int i = 0; i < 1000; i++) begin
      step(1'b1, NB'(16'h8000 + i), 1'b1, p, g, w);
      n_vec++;
      if (!p || g !== w) begin n_bad++; $display("FAIL b2b_data[%0d]: got %h want %h", i, g, w); end
      n_vec++;
      if (count !== 10'd5) begin n_bad++; $display("FAIL b2b_count[%0d]: got %0d want 5", i, count); end
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, 1'b1, p, g, w);
      n_vec++;
      if (!p || g !== w || g !== NB'(16'h8000 + 995 + i)) begin
        n_bad++; $display("FAIL b2b_tail[%0d]: got %h want %h", i, g, w);
      end
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid();
    bit p; logic [NB-1:0] g, w;
    for (int i = 0; i < 300; i++) step(1'b1, NB'(16'h2000 + i), 1'b0, p, g, w);
    n_vec++; if (count !== 10'd300) begin n_bad++; $display("FAIL mid_fill_count: got %0d want 300", count); end
    do_reset(1'b1, 1'b1);
    n_vec++; if (count !== 10'd0) begin n_bad++; $display("FAIL mid_reset_count: got %0d want 0", count); end
    n_vec++; if (rd_if.valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset_valid: got %b want 0", rd_if.valid); end
    verbose = 1'b1;
    step(1'b1, 16'hABCD, 1'b0, p, g, w);
    n_vec++; if (rd_if.data !== 16'hABCD) begin n_bad++; $display("FAIL mid_first_data: got %h want abcd", rd_if.data); end
    step(1'b0, '0, 1'b1, p, g, w);
    n_vec++; if (!p || g !== w) begin n_bad++; $display("FAIL mid_pop: got %h want %h", g, w); end
    n_vec++; if (rd_if.valid !== 1'b0) begin n_bad++; $display("FAIL mid_after_valid: got %b want 0", rd_if.valid); end
    verbose = 1'b0;
    $display("test_reset_mid done");
  endtask

  initial begin
    rst         = 1'b1;
    wr_if.valid = 1'b0;
    wr_if.data  = '0;
    rd_if.ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_fill_drain();
    test_full_rw();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
